// File: rtl/mips_run_pkg.sv
// Shared state encoding and default parameters for the MIPS run controller
// and the benches that drive it.
package mips_run_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RST  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RST  = ST_RST,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } run_state_t;

  localparam int DEF_PC_W        = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_RST_CYCLES  = 2;
  localparam int DEF_MAX_CYCLES  = 50;
  localparam int DEF_HALT_REPEAT = 4;

endpackage

// File: rtl/mips_loop_detect.sv
// Watches the W-stage commit stream for a core spinning on a one- or
// two-instruction loop and pulses halt_hit once the streak is long enough.
module mips_loop_detect
  import mips_run_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  output logic            halt_hit
);

  localparam int HW = $clog2(HALT_REPEAT + 1);
  localparam logic [HW-1:0] HIT_MAX  = HW'(HALT_REPEAT);
  localparam logic [HW-1:0] HIT_LAST = HW'(HALT_REPEAT - 1);

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == HIT_MAX) ? v : v + 1'b1;
  endfunction

  logic [PC_W-1:0] prev1, prev2;
  logic            prev1_vld, prev2_vld;
  logic [HW-1:0]   hit_cnt;
  logic            commit;
  logic            hit;

  assign commit = en & wb_valid;
  // prev1 catches a self-branch, prev2 a branch whose delay slot commits in between
  assign hit = (prev1_vld && (wb_pc == prev1)) || (prev2_vld && (wb_pc == prev2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev1_vld <= 1'b0;
      prev2_vld <= 1'b0;
      hit_cnt   <= '0;
      halt_hit  <= 1'b0;
    end else if (clear) begin
      prev1_vld <= 1'b0;
      prev2_vld <= 1'b0;
      hit_cnt   <= '0;
      halt_hit  <= 1'b0;
    end else begin
      halt_hit <= 1'b0;
      if (commit) begin
        prev1_vld <= 1'b1;
        prev2_vld <= prev1_vld;
        if (hit) begin
          hit_cnt  <= sat_inc(hit_cnt);
          halt_hit <= (hit_cnt == HIT_LAST);
        end else begin
          hit_cnt <= '0;
        end
      end
    end
  end

  // PC history is data; its validity bits above decide whether it is used
  always_ff @(posedge clk) begin
    if (commit) begin
      prev1 <= wb_pc;
      prev2 <= prev1;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: holds the core in reset, lets it run, counts cycles and
// commits, and stops on a detected halt loop or on the cycle budget.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             wb_valid,
  input  logic [PC_W-1:0]  wb_pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]    RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

  run_state_t  state;
  logic [RW-1:0] rst_cnt;
  logic        halt_hit;
  logic        ld_clear;
  logic        ld_en;

  assign ld_clear = (state == RST);
  assign ld_en    = (state == RUN);

  mips_loop_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_loop_detect (
    .clk      (clk),
    .reset    (reset),
    .clear    (ld_clear),
    .en       (ld_en),
    .wb_valid (wb_valid),
    .wb_pc    (wb_pc),
    .halt_hit (halt_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      cpu_reset <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // results of the previous run are wiped as RST is entered
          if (start) begin
            state     <= RST;
            rst_cnt   <= '0;
            done      <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
          end
        end
        RST: begin
          if (rst_cnt == RST_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (wb_valid) instr_cnt <= instr_cnt + 1'b1;
          // halt wins when it lands on the last budgeted cycle
          if (halt_hit || (cycle_cnt == CYC_LAST)) begin
            state     <= DONE;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b1;
            halted    <= halt_hit;
            timeout   <= ~halt_hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: directed run table, hand sequences
// for reset/start timing, and random commit traces against a trace model.
module tb_mips_run_ctrl;
  import mips_run_pkg::*;

  localparam int PC_W        = DEF_PC_W;
  localparam int CNT_W       = DEF_CNT_W;
  localparam int RST_CYCLES  = DEF_RST_CYCLES;
  localparam int MAX_CYCLES  = DEF_MAX_CYCLES;
  localparam int HALT_REPEAT = DEF_HALT_REPEAT;
  localparam int TL          = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             wb_valid;
  logic [PC_W-1:0]  wb_pc;
  logic             cpu_reset, running, done, halted, timeout;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  mips_run_ctrl #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (RST_CYCLES),
    .MAX_CYCLES  (MAX_CYCLES),
    .HALT_REPEAT (HALT_REPEAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wb_valid  (wb_valid),
    .wb_pc     (wb_pc),
    .cpu_reset (cpu_reset),
    .running   (running),
    .done      (done),
    .halted    (halted),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int seen;

  logic            drv_v  [TL];
  logic [PC_W-1:0] drv_pc [TL];

  typedef struct {
    string           nm;
    int              first;
    int              gap;
    int              n;
    logic [0:9][31:0] pcs;
    bit              eh;
    bit              et;
    int              ec;
    int              ei;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_drive();
    for (int i = 0; i < TL; i++) begin
      drv_v[i]  = 1'b0;
      drv_pc[i] = '0;
    end
  endtask

  // Expected outcome from the commit trace: streak of repeat commits,
  // detector reports one cycle after the deciding commit, budget caps the run.
  task automatic model(output bit eh, output bit et, output int ec, output int ei);
    logic [PC_W-1:0] h[$];
    int streak;
    int halt_at;
    int last;
    eh = 1'b0; ei = 0; streak = 0; halt_at = -1; last = MAX_CYCLES - 1;
    for (int t = 0; t < MAX_CYCLES; t++) begin
      if (t == halt_at) begin
        eh = 1'b1;
        last = t;
        if (drv_v[t]) ei++;
        break;
      end
      if (drv_v[t]) begin
        ei++;
        if ((h.size() > 0 && h[0] == drv_pc[t]) || (h.size() > 1 && h[1] == drv_pc[t]))
          streak++;
        else
          streak = 0;
        h.push_front(drv_pc[t]);
        if (h.size() > 2) void'(h.pop_back());
        if (streak == HALT_REPEAT && halt_at < 0) halt_at = t + 1;
      end
    end
    ec = last + 1;
    et = !eh;
  endtask

  // Starts a run from IDLE/DONE and plays drv_* by RUN-cycle index until done.
  task automatic do_run(input string nm);
    bit ok;
    int t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ":rst_flags"}, {done, halted, timeout, running, cpu_reset}, 5'b00001);
    chk({nm, ":rst_cyc"}, cycle_cnt, 0);
    chk({nm, ":rst_instr"}, instr_cnt, 0);
    ok = 1'b0;
    for (int i = 0; i < RST_CYCLES + 4; i++) begin
      if (running) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    seen = 0;
    if (!ok) begin
      chk({nm, ":reach_run"}, 0, 1);
    end else begin
      t = 0;
      while (!done && t < MAX_CYCLES + 8) begin
        wb_valid = drv_v[t];
        wb_pc    = drv_pc[t];
        start    = (t == 3);
        if (running) seen++;
        @(posedge clk); #1;
        t++;
      end
      wb_valid = 1'b0;
      start    = 1'b0;
    end
  endtask

  task automatic check_result(input string nm, input bit eh, input bit et,
                              input int ec, input int ei);
    chk({nm, ":done"}, done, 1);
    chk({nm, ":halted"}, halted, eh);
    chk({nm, ":timeout"}, timeout, et);
    chk({nm, ":cycle_cnt"}, cycle_cnt, ec);
    chk({nm, ":instr_cnt"}, instr_cnt, ei);
    chk({nm, ":run_cycles"}, seen, ec);
    chk({nm, ":frozen"}, {cpu_reset, running}, 2'b10);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ":ctl"}, {cpu_reset, running, done, halted, timeout}, 5'b10000);
    chk({nm, ":cyc"}, cycle_cnt, 0);
    chk({nm, ":instr"}, instr_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit eh, et;
    int ec, ei;
    int c;
    logic [PC_W-1:0] base;
    int npool, vprob;

    vt[0] = '{"dslot_loop", 0, 0, 9,
              {32'h3000, 32'h3004, 32'h3008, 32'h300c, 32'h3010,
               32'h300c, 32'h3010, 32'h300c, 32'h3010, 32'h0}, 1, 0, 10, 9};
    vt[1] = '{"self_loop", 0, 0, 6,
              {32'h100, 32'h104, 32'h104, 32'h104, 32'h104, 32'h104,
               32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 7, 6};
    vt[2] = '{"no_commit", 0, 0, 0, '0, 0, 1, 50, 0};
    vt[3] = '{"streak_break", 0, 0, 6,
              {32'h200, 32'h200, 32'h200, 32'h200, 32'h208, 32'h20c,
               32'h0, 32'h0, 32'h0, 32'h0}, 0, 1, 50, 6};
    vt[4] = '{"three_pc", 0, 0, 9,
              {32'h10, 32'h14, 32'h18, 32'h10, 32'h14, 32'h18,
               32'h10, 32'h14, 32'h18, 32'h0}, 0, 1, 50, 9};
    vt[5] = '{"gap_self", 0, 2, 6,
              {32'h100, 32'h104, 32'h104, 32'h104, 32'h104, 32'h104,
               32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 17, 6};
    vt[6] = '{"zero_pc_hist", 0, 0, 5,
              {32'h0, 32'h0, 32'h0, 32'h0, 32'h8,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0, 1, 50, 5};
    vt[7] = '{"commit_in_pulse", 0, 0, 8,
              {32'h104, 32'h104, 32'h104, 32'h104, 32'h104, 32'h104,
               32'h104, 32'h104, 32'h0, 32'h0}, 1, 0, 6, 6};
    vt[8] = '{"halt_at_last", 44, 0, 5,
              {32'h500, 32'h500, 32'h500, 32'h500, 32'h500,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1, 0, 50, 5};
    vt[9] = '{"halt_after_budget", 45, 0, 5,
              {32'h500, 32'h500, 32'h500, 32'h500, 32'h500,
               32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0, 1, 50, 5};

    reset = 1'b0; start = 1'b0; wb_valid = 1'b0; wb_pc = '0;
    clear_drive();
    #12;
    chk_reset_vals("por");
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    // Start timing, start ignored in RST, commits ignored outside RUN
    start = 1'b1; wb_valid = 1'b1; wb_pc = 32'h44;
    @(posedge clk); #1;
    chk("t1:rst1", {cpu_reset, running}, 2'b10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t1:rst2", {cpu_reset, running}, 2'b10);
    @(posedge clk); #1;
    wb_valid = 1'b0;
    chk("t1:run", {cpu_reset, running}, 2'b01);
    chk("t1:cyc0", cycle_cnt, 0);
    chk("t1:instr0", instr_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("t1:cyc%0d", k), cycle_cnt, k);
    end

    // Asynchronous reset in the middle of a run
    c = 0;
    while (cycle_cnt != 10 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t5:reach10", cycle_cnt, 10);
    #2 reset = 1'b0;
    #1 chk_reset_vals("t5:async");
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("t5:released");
    clear_drive();
    do_run("t5:clean");
    check_result("t5:clean", 0, 1, 50, 0);

    // Restart from DONE after a timeout reproduces the run
    do_run("t6:again");
    check_result("t6:again", 0, 1, 50, 0);

    for (int v = 0; v < 10; v++) begin
      clear_drive();
      for (int i = 0; i < vt[v].n; i++) begin
        drv_v[vt[v].first + i * (vt[v].gap + 1)]  = 1'b1;
        drv_pc[vt[v].first + i * (vt[v].gap + 1)] = vt[v].pcs[i];
      end
      do_run(vt[v].nm);
      check_result(vt[v].nm, vt[v].eh, vt[v].et, vt[v].ec, vt[v].ei);
    end

    for (int r = 0; r < 40; r++) begin
      clear_drive();
      vprob = $urandom_range(1, 4);
      npool = $urandom_range(2, 6);
      base  = PC_W'($urandom_range(0, 255)) << 8;
      for (int t = 0; t < TL; t++) begin
        drv_v[t]  = ($urandom_range(0, 3) < vprob);
        drv_pc[t] = base + PC_W'($urandom_range(0, npool - 1) * 4);
      end
      model(eh, et, ec, ei);
      do_run($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r), eh, et, ec, ei);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
